// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg
// Shared constants for the multi-port register file and its busy scoreboard.
// No ports; imported by the interface, the top and the scoreboard sub-module.
package regfile_mp_pkg;

  localparam int          XLEN_DEF     = 64;
  localparam int          NREG_DEF     = 32;
  localparam logic [63:0] ZERO_WORD    = 64'h0;
  localparam int          REG_NOP      = 0;      // architectural x0
  localparam logic        WRITE_ENABLE = 1'b1;
  localparam logic        RST_ENABLE   = 1'b0;   // cpu_rst_n level that holds reset
  // Issue and writeback to the same register on one edge: the new producer
  // supersedes the retiring one, so the busy bit ends up set.
  localparam logic        SB_SET_WINS  = 1'b1;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if
// Bundles the read/write/issue signals of the register file.
//   master : drives we/wa/wd, ra, iss_valid/iss_rd; receives rd, rbusy, busy_o, regs_o
//   slave  : the register file itself (opposite directions)
// Vectors are flattened; port k occupies slice k.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) ();

  localparam int AW = $clog2(NREG);

  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic [NREG-1:0]     busy_o;
  logic [NREG*XLEN-1:0] regs_o;

  modport master (
    output we, wa, wd, ra, iss_valid, iss_rd,
    input  rd, rbusy, busy_o, regs_o
  );

  modport slave (
    input  we, wa, wd, ra, iss_valid, iss_rd,
    output rd, rbusy, busy_o, regs_o
  );

endinterface

// File: rtl/regfile_sb.sv
// regfile_sb
// Per-register busy scoreboard: one bit per architectural register, set on
// issue, cleared on writeback, issue wins when both hit the same register.
// Bit 0 is never set.
//   i_clk   : core clock
//   i_rst_n : async active-low reset, clears all busy bits
//   i_set   : one-hot issue destination (already qualified by iss_valid)
//   i_clr   : per-register writeback hit for this cycle
//   o_busy  : registered busy vector
module regfile_sb
  import regfile_mp_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREG-1:0] i_set,
  input  logic [NREG-1:0] i_clr,
  output logic [NREG-1:0] o_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_next;

  always_comb begin
    w_next = r_busy;
    for (int r = 0; r < NREG; r++) begin
      if (i_set[r] && i_clr[r]) begin
        w_next[r] = SB_SET_WINS;
      end else if (i_set[r]) begin
        w_next[r] = 1'b1;
      end else if (i_clr[r]) begin
        w_next[r] = 1'b0;
      end
    end
    w_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_next;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port integer register file with same-cycle write-to-read bypass and
// an integrated RAW busy scoreboard.
//   cpu_clk_50M : core clock, all state updates on its rising edge
//   cpu_rst_n   : async active-low reset, clears registers and busy bits
//   bus         : regfile_mp_if.slave -- NWR write ports, NRD combinational
//                 read ports with rbusy, issue port, busy_o/regs_o debug views
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input  logic          cpu_clk_50M,
  input  logic          cpu_rst_n,
  regfile_mp_if.slave   bus
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] r_regs [1:NREG-1];   // x0 has no storage
  logic [XLEN-1:0] w_view [NREG];       // architectural view incl. this cycle's writes
  logic [NREG-1:0] w_wr_hit;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_busy;
  logic            w_rst_act;

  assign w_rst_act = (cpu_rst_n == RST_ENABLE);

  // Write decode and bypass view. Ports are scanned in ascending order so
  // the highest-indexed port targeting an address overrides the lower ones;
  // the same winner is what gets stored on the edge.
  always_comb begin : wr_decode
    logic [AW-1:0] v_wa;
    v_wa      = '0;
    w_wr_hit  = '0;
    w_view[0] = XLEN'(ZERO_WORD);
    for (int r = 1; r < NREG; r++) begin
      w_view[r] = r_regs[r];
    end
    for (int j = 0; j < NWR; j++) begin
      v_wa = bus.wa[j*AW +: AW];
      if (bus.we[j] == WRITE_ENABLE && int'(v_wa) != REG_NOP) begin
        w_wr_hit[v_wa] = 1'b1;
        w_view[v_wa]   = bus.wd[j*XLEN +: XLEN];
      end
    end
    // Reset forces every visible value to zero, including bypassed data.
    if (w_rst_act) begin
      for (int r = 0; r < NREG; r++) begin
        w_view[r] = XLEN'(ZERO_WORD);
      end
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int r = 1; r < NREG; r++) begin
        r_regs[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (w_wr_hit[r]) begin
          r_regs[r] <= w_view[r];
        end
      end
    end
  end

  always_comb begin : iss_decode
    w_set = '0;
    if (bus.iss_valid) begin
      w_set[bus.iss_rd] = 1'b1;
    end
    w_set[0] = 1'b0;
  end

  regfile_sb #(
    .NREG (NREG)
  ) u_sb (
    .i_clk   (cpu_clk_50M),
    .i_rst_n (cpu_rst_n),
    .i_set   (w_set),
    .i_clr   (w_wr_hit),
    .o_busy  (w_busy)
  );

  // A same-cycle write means the value is already available, so it masks busy.
  always_comb begin : rd_mux
    logic [AW-1:0] v_ra;
    v_ra      = '0;
    bus.rd    = '0;
    bus.rbusy = '0;
    for (int k = 0; k < NRD; k++) begin
      v_ra = bus.ra[k*AW +: AW];
      bus.rd[k*XLEN +: XLEN] = w_view[v_ra];
      bus.rbusy[k] = w_busy[v_ra] && !w_wr_hit[v_ra] && (int'(v_ra) != REG_NOP);
    end
  end

  always_comb begin : regs_view
    bus.regs_o = '0;
    for (int i = 0; i < NREG; i++) begin
      bus.regs_o[i*XLEN +: XLEN] = w_view[i];
    end
  end

  assign bus.busy_o = w_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Directed and randomised bench for regfile_mp in an NRD=4 / NWR=2 build.
// Expected outputs are pushed into a scoreboard queue when stimulus is driven
// and popped/compared once the combinational outputs have settled.
module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int NWR  = 2;
  localparam int AW   = $clog2(NREG);

  logic cpu_clk_50M = 1'b0;
  logic cpu_rst_n   = 1'b0;

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .bus         (bus)
  );

  // stimulus
  logic [NWR-1:0]  s_we;
  logic [AW-1:0]   s_wa [NWR];
  logic [XLEN-1:0] s_wd [NWR];
  logic [AW-1:0]   s_ra [NRD];
  logic            s_iss;
  logic [AW-1:0]   s_iss_rd;

  // reference model state
  logic [XLEN-1:0] m_regs [NREG];
  logic [NREG-1:0] m_busy;

  typedef struct packed {
    logic [NRD*XLEN-1:0]  rd;
    logic [NRD-1:0]       rbusy;
    logic [NREG-1:0]      busy;
    logic [NREG*XLEN-1:0] regs;
  } exp_t;

  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    s_we = '0;
    for (int j = 0; j < NWR; j++) begin
      s_wa[j] = '0;
      s_wd[j] = '0;
    end
    for (int k = 0; k < NRD; k++) s_ra[k] = '0;
    s_iss    = 1'b0;
    s_iss_rd = '0;
  endtask

  task automatic apply();
    for (int j = 0; j < NWR; j++) begin
      bus.we[j]              = s_we[j];
      bus.wa[j*AW +: AW]     = s_wa[j];
      bus.wd[j*XLEN +: XLEN] = s_wd[j];
    end
    for (int k = 0; k < NRD; k++) bus.ra[k*AW +: AW] = s_ra[k];
    bus.iss_valid = s_iss;
    bus.iss_rd    = s_iss_rd;
  endtask

  function automatic logic m_hit(input int a);
    logic h;
    h = 1'b0;
    for (int j = 0; j < NWR; j++)
      if (s_we[j] && int'(s_wa[j]) == a && a != 0) h = 1'b1;
    return h;
  endfunction

  function automatic logic [XLEN-1:0] m_view(input int a);
    logic [XLEN-1:0] v;
    if (!cpu_rst_n || a == 0) return '0;
    v = m_regs[a];
    for (int j = 0; j < NWR; j++)
      if (s_we[j] && int'(s_wa[j]) == a) v = s_wd[j];
    return v;
  endfunction

  // Drive current stimulus, push expectation, let it settle, pop and compare.
  task automatic sample();
    exp_t e;
    exp_t g;
    apply();
    if (!cpu_rst_n) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      m_busy = '0;
    end
    e = '0;
    for (int k = 0; k < NRD; k++) begin
      e.rd[k*XLEN +: XLEN] = m_view(int'(s_ra[k]));
      e.rbusy[k] = cpu_rst_n && (s_ra[k] != 0) && m_busy[s_ra[k]] && !m_hit(int'(s_ra[k]));
    end
    e.busy = m_busy;
    for (int i = 0; i < NREG; i++) e.regs[i*XLEN +: XLEN] = m_view(i);
    sb_q.push_back(e);
    #3;
    chk("sb_depth", 64'(sb_q.size()), 64'd1);
    if (sb_q.size() != 0) begin
      g = sb_q.pop_front();
      for (int k = 0; k < NRD; k++)
        chk($sformatf("rd%0d", k), bus.rd[k*XLEN +: XLEN], g.rd[k*XLEN +: XLEN]);
      chk("rbusy", 64'(bus.rbusy), 64'(g.rbusy));
      chk("busy_o", 64'(bus.busy_o), 64'(g.busy));
      for (int i = 0; i < NREG; i++)
        chk($sformatf("regs_o%0d", i), bus.regs_o[i*XLEN +: XLEN], g.regs[i*XLEN +: XLEN]);
    end
  endtask

  // Commit the model's next state for the coming edge, then step past it.
  task automatic advance();
    logic [NREG-1:0] clr;
    if (cpu_rst_n) begin
      clr = '0;
      for (int j = 0; j < NWR; j++) begin
        if (s_we[j] && s_wa[j] != 0) begin
          m_regs[s_wa[j]] = s_wd[j];
          clr[s_wa[j]]    = 1'b1;
        end
      end
      for (int r = 1; r < NREG; r++) begin
        if (s_iss && int'(s_iss_rd) == r) m_busy[r] = 1'b1;
        else if (clr[r])                  m_busy[r] = 1'b0;
      end
    end
    @(posedge cpu_clk_50M);
    #1;
  endtask

  initial begin : stim
    int rst_left;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_busy = '0;
    idle();
    cpu_rst_n = 1'b0;
    apply();
    @(posedge cpu_clk_50M);
    #1;

    // reset state, with a pending write that must not leak through
    s_we = 2'b01; s_wa[0] = 5'd4; s_wd[0] = 64'h55; s_ra[0] = 5'd4;
    sample();
    chk("rst_rd0", bus.rd[XLEN-1:0], 64'h0);
    chk("rst_busy", 64'(bus.busy_o), 64'h0);
    advance();

    // write x5 and issue to it, then reset mid-cycle with a write pending
    cpu_rst_n = 1'b1;
    idle();
    s_we = 2'b01; s_wa[0] = 5'd5; s_wd[0] = 64'h1234; s_ra[0] = 5'd5;
    s_iss = 1'b1; s_iss_rd = 5'd5;
    sample();
    chk("x5_bypass", bus.rd[XLEN-1:0], 64'h1234);
    advance();
    idle(); s_ra[0] = 5'd5;
    sample();
    chk("x5_stored", bus.rd[XLEN-1:0], 64'h1234);
    chk("x5_busy", 64'(bus.busy_o[5]), 64'h1);
    advance();
    cpu_rst_n = 1'b0;
    s_we = 2'b01; s_wa[0] = 5'd5; s_wd[0] = 64'h5678;
    sample();
    chk("rst_mid_rd", bus.rd[XLEN-1:0], 64'h0);
    chk("rst_mid_busy", 64'(bus.busy_o), 64'h0);
    advance();
    cpu_rst_n = 1'b1;
    idle(); s_ra[0] = 5'd5;
    sample();
    chk("x5_after_rst", bus.rd[XLEN-1:0], 64'h0);
    advance();

    // bypass
    idle(); s_we = 2'b01; s_wa[0] = 5'd7; s_wd[0] = 64'hDEAD_BEEF; s_ra[1] = 5'd7;
    sample();
    chk("byp_x7", bus.rd[XLEN +: XLEN], 64'hDEAD_BEEF);
    advance();
    idle(); s_ra[1] = 5'd7;
    sample();
    chk("x7_stored", bus.rd[XLEN +: XLEN], 64'hDEAD_BEEF);
    advance();

    // x0 writes ignored
    idle(); s_we = 2'b01; s_wa[0] = 5'd0; s_wd[0] = 64'hFFFF;
    sample();
    chk("x0_byp", bus.rd[XLEN-1:0], 64'h0);
    advance();
    idle();
    sample();
    chk("x0_read", bus.rd[XLEN-1:0], 64'h0);
    advance();

    // collision: port 1 wins
    idle(); s_we = 2'b11; s_wa[0] = 5'd3; s_wa[1] = 5'd3;
    s_wd[0] = 64'hAA; s_wd[1] = 64'hBB; s_ra[0] = 5'd3;
    sample();
    chk("coll_byp", bus.rd[XLEN-1:0], 64'hBB);
    advance();
    idle(); s_ra[0] = 5'd3;
    sample();
    chk("coll_stored", bus.rd[XLEN-1:0], 64'hBB);
    advance();

    // scoreboard: issue x9 in cycle 1, write in cycle 5
    idle(); s_iss = 1'b1; s_iss_rd = 5'd9; s_ra[0] = 5'd9;
    sample();
    chk("sb_c1_rbusy", 64'(bus.rbusy[0]), 64'h0);
    advance();
    for (int c = 2; c <= 4; c++) begin
      idle(); s_ra[0] = 5'd9;
      sample();
      chk($sformatf("sb_c%0d_rbusy", c), 64'(bus.rbusy[0]), 64'h1);
      advance();
    end
    idle(); s_we = 2'b01; s_wa[0] = 5'd9; s_wd[0] = 64'h99; s_ra[0] = 5'd9;
    sample();
    chk("sb_c5_rbusy", 64'(bus.rbusy[0]), 64'h0);
    chk("sb_c5_busy9", 64'(bus.busy_o[9]), 64'h1);
    advance();
    idle(); s_ra[0] = 5'd9;
    sample();
    chk("sb_c6_busy9", 64'(bus.busy_o[9]), 64'h0);
    advance();

    // issue and write x9 on the same edge: issue wins
    idle(); s_iss = 1'b1; s_iss_rd = 5'd9; s_we = 2'b10; s_wa[1] = 5'd9; s_wd[1] = 64'h77;
    sample();
    advance();
    idle(); s_ra[2] = 5'd9;
    sample();
    chk("set_wins_busy9", 64'(bus.busy_o[9]), 64'h1);
    chk("set_wins_rbusy", 64'(bus.rbusy[2]), 64'h1);
    advance();
    idle(); s_we = 2'b01; s_wa[0] = 5'd9; s_wd[0] = 64'h78;
    sample();
    advance();

    // issue to x0
    idle(); s_iss = 1'b1; s_iss_rd = 5'd0;
    sample();
    advance();
    idle();
    sample();
    chk("iss_x0_busy", 64'(bus.busy_o), 64'h0);
    advance();

    // randomised traffic with injected async resets
    rst_left = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!cpu_rst_n && rst_left == 0) cpu_rst_n = 1'b1;
      else if (cpu_rst_n && $urandom_range(0, 199) == 0) begin
        cpu_rst_n = 1'b0;
        rst_left  = $urandom_range(1, 2);
      end
      for (int j = 0; j < NWR; j++) begin
        s_we[j] = ($urandom_range(0, 2) != 0);
        s_wa[j] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
        s_wd[j] = {$urandom, $urandom};
      end
      for (int k = 0; k < NRD; k++)
        s_ra[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      s_iss    = ($urandom_range(0, 2) == 0);
      s_iss_rd = ($urandom_range(0, 1) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      sample();
      advance();
      if (rst_left > 0) rst_left--;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
